cog_axis_frame_tx: RTL and testbench
====================================

Name: cog_axis_frame_tx

Overview:
- AXI4-Stream video master that produces the 2*DATA_WIDTH pixel stream consumed by the CoG receiver FSM.
- Takes raw image pixels from a valid/ready pixel source and derives a binary mask byte by thresholding each pixel.
- Packs {mask, image} into tdata, generates tuser on the first pixel of the frame and tlast on the last pixel of each line.
- Inserts HBLANK idle cycles (tvalid low) between lines and honours tready backpressure. Sits between the image filter chain and the CoG receiver.

Parameters:
- DATA_WIDTH, 8, width of the image and mask bytes.
- HBLANK, 4, minimum tvalid-low cycles after each line's last beat is accepted (1..15).
- BORDER, 2, number of forced-black pixels at each line edge when CoG_TX_BORDER_BLACK_EN is defined.

Ports:
- i_sys_clk  in  1  system clock; all logic on the rising edge.
- i_sys_aresetn  in  1  reset, asynchronous, active-low.
- WIDTH  in  11  pixels per line; sampled on accepted i_start.
- HEIGHT  in  11  lines per frame; sampled on accepted i_start.
- i_start  in  1  frame request pulse.
- i_threshold  in  DATA_WIDTH  mask threshold; sampled on accepted i_start.
- i_pix_data  in  DATA_WIDTH  source pixel.
- i_pix_valid  in  1  source pixel valid.
- o_pix_ready  out  1  pixel accepted when i_pix_valid && o_pix_ready.
- m_axis_tdata  out  2*DATA_WIDTH  [2*DW-1:DW] = mask, [DW-1:0] = image.
- m_axis_tvalid, m_axis_tuser, m_axis_tlast  out  1 each  AXIS sideband.
- m_axis_tready  in  1  downstream ready.
- o_busy  out  1  high from accepted start until frame done.
- o_frame_done  out  1  one-cycle pulse when the last beat of the frame is accepted.

Behaviour:
- Reset: all outputs 0. tdata = 0, state = IDLE, counters = 0.
- FSM states: IDLE, ACTIVE, BLANK, FRAME_END.
- IDLE:
  - i_start with WIDTH >= 4 && HEIGHT >= 1 latches WIDTH, HEIGHT and threshold, then moves to ACTIVE, o_busy = 1.
  - Otherwise the start is ignored.
  - i_start outside IDLE is ignored.
- ACTIVE:
  - o_pix_ready = !m_axis_tvalid || m_axis_tready. This is a combinational path from tready.
  - On accept, the output register loads on the next edge: image = i_pix_data; mask = all-ones if i_pix_data >= threshold, else 0; tvalid = 1.
  - tuser = (pix_cnt == 0 && line_cnt == 0).
  - tlast = (pix_cnt == WIDTH_l - 1).
  - Latency from pixel accept to tvalid is 1 cycle.
- Output register:
  - tdata, tuser and tlast stay stable while tvalid && !tready.
  - tvalid clears on tready when no new pixel is loaded in the same cycle.
- Counters:
  - pix_cnt advances on each accept and wraps to 0 after WIDTH_l - 1.
  - line_cnt advances on that wrap.
  - After the last pixel of the line: if line_cnt == HEIGHT_l - 1, go to FRAME_END, otherwise go to BLANK.
- BLANK:
  - o_pix_ready = 0.
  - The blank counter counts only cycles with tvalid = 0, so a stalled tlast beat does not eat the gap.
  - After HBLANK such cycles, return to ACTIVE.
- FRAME_END:
  - o_pix_ready = 0.
  - When the final beat (tlast = 1) is accepted, pulse o_frame_done, clear o_busy and go to IDLE.
  - o_frame_done is registered and asserts the cycle after the handshake.
- Simultaneous events: tready and a new pixel accept in the same cycle replaces the beat without a tvalid bubble.
- Reset mid-frame: immediate return to reset values, with no partial tlast or tuser emitted afterwards.
- WIDTH/HEIGHT/threshold input changes mid-frame have no effect.

Optional Feature:
- Macro CoG_TX_BORDER_BLACK_EN.
- Defined: pixels with pix_cnt < BORDER or pix_cnt >= WIDTH_l - BORDER are emitted with image = 0 and mask = 0, regardless of input. The source pixel is still consumed. This guarantees the black line edges the receiver relies on to close figures.
- Undefined: image passes through and mask is purely the threshold result.

Decomposition:
- Shared package cog_pkg holds:
  - the state typedef (logic [1:0] enum IDLE/ACTIVE/BLANK/FRAME_END);
  - MASK_ON = '1 and MASK_OFF = '0 constants;
  - a function pack_tdata(mask, image).
- One sub-module, cog_axis_out_reg: the single-stage AXIS output register with load/hold/clear logic. It is reusable by other stream masters.

Test Plan:
- WIDTH = 8, HEIGHT = 2, threshold = 0x80, tready = 1, pixels 0x00..0x0F continuous.
  - Expect 16 beats; tuser only on beat 0; tlast on beats 7 and 15.
  - Mask = 0x00 for all pixels (all < 0x80); tdata beat 3 = 0x0003.
  - Exactly 4 tvalid-low cycles between beats 7 and 8; o_frame_done pulses once.
- Same frame, pixel 0x90 at index 5.
  - Beat 5 tdata = 0xFF90; a pixel equal to 0x80 yields 0xFF80.
- tready held low for 5 cycles while beat 2 is valid.
  - tdata, tuser and tlast stay unchanged; o_pix_ready = 0 during the stall; no beats lost or duplicated.
- tready low on a tlast beat for 3 cycles.
  - HBLANK counting starts only after acceptance: still 4 idle cycles before the next line's beat.
- i_start during a frame, and WIDTH = 3 with i_start in IDLE.
  - Both ignored: o_busy unchanged, no tvalid.
- i_sys_aresetn low mid-line 1.
  - All outputs are 0 within the same cycle; after release and a new start, the first beat carries tuser = 1.

Source files
------------

// File: rtl/cog_pkg.sv
// Shared types and helpers for the CoG AXI4-Stream frame transmitter and its output register.
package cog_pkg;

   localparam int COG_DW = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      BLANK,
      FRAME_END
   } state_t;

   localparam logic [COG_DW-1:0] MASK_ON  = '1;
   localparam logic [COG_DW-1:0] MASK_OFF = '0;

   // The mask occupies the upper half of tdata so the receiver can test one byte.
   function automatic logic [2*COG_DW-1:0] pack_tdata(input logic [COG_DW-1:0] mask,
                                                      input logic [COG_DW-1:0] image);
      return {mask, image};
   endfunction

endpackage

// File: rtl/cog_axis_out_reg.sv
// Single-stage AXI4-Stream output register: load a beat, hold it under backpressure, clear on accept.
module cog_axis_out_reg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         load_user,
   input  logic         load_last,
   input  logic         tready,
   output logic [W-1:0] tdata,
   output logic         tvalid,
   output logic         tuser,
   output logic         tlast
);

   // The caller only asserts load when the slot is empty or being drained this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdata  <= '0;
         tvalid <= 1'b0;
         tuser  <= 1'b0;
         tlast  <= 1'b0;
      end else if (load) begin
         tdata  <= load_data;
         tvalid <= 1'b1;
         tuser  <= load_user;
         tlast  <= load_last;
      end else if (tready) begin
         tvalid <= 1'b0;
         tuser  <= 1'b0;
         tlast  <= 1'b0;
      end
   end

endmodule

// File: rtl/cog_axis_frame_tx.sv
// CoG AXI4-Stream video master: thresholds source pixels into {mask, image} beats with line blanking.
// Optional macro CoG_TX_BORDER_BLACK_EN forces BORDER black pixels at both edges of every line.
module cog_axis_frame_tx
   import cog_pkg::*;
#(
   parameter int DATA_WIDTH = COG_DW,
   parameter int HBLANK     = 4,
   parameter int BORDER     = 2
) (
   input  logic                    i_sys_clk,
   input  logic                    i_sys_aresetn,
   input  logic [10:0]             WIDTH,
   input  logic [10:0]             HEIGHT,
   input  logic                    i_start,
   input  logic [DATA_WIDTH-1:0]   i_threshold,
   input  logic [DATA_WIDTH-1:0]   i_pix_data,
   input  logic                    i_pix_valid,
   output logic                    o_pix_ready,
   output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tuser,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic                    o_busy,
   output logic                    o_frame_done
);

`ifdef CoG_TX_BORDER_BLACK_EN
   localparam bit BORDER_EN = 1'b1;
`else
   localparam bit BORDER_EN = 1'b0;
`endif

   localparam logic [10:0] BORDER_W   = 11'(BORDER);
   localparam logic [3:0]  BLANK_LAST = 4'(HBLANK - 1);

   state_t                  state;
   logic [10:0]             width_l;
   logic [10:0]             height_l;
   logic [DATA_WIDTH-1:0]   thr_l;
   logic [10:0]             pix_cnt;
   logic [10:0]             line_cnt;
   logic [3:0]              blank_cnt;
   logic                    accept;
   logic                    black;
   logic [DATA_WIDTH-1:0]   image;
   logic [DATA_WIDTH-1:0]   mask;
   logic                    next_user;
   logic                    next_last;
   logic [2*DATA_WIDTH-1:0] next_tdata;

   assign o_pix_ready = (state == ACTIVE) && (!m_axis_tvalid || m_axis_tready);
   assign accept      = i_pix_valid && o_pix_ready;
   assign next_tdata  = pack_tdata(mask, image);

   always_comb begin
      black     = BORDER_EN && ((pix_cnt < BORDER_W) || (pix_cnt >= width_l - BORDER_W));
      image     = black ? '0 : i_pix_data;
      mask      = (!black && (i_pix_data >= thr_l)) ? MASK_ON : MASK_OFF;
      next_user = (pix_cnt == 11'd0) && (line_cnt == 11'd0);
      next_last = (pix_cnt == width_l - 11'd1);
   end

   cog_axis_out_reg #(
      .W(2*DATA_WIDTH)
   ) u_out_reg (
      .clk       (i_sys_clk),
      .rst_n     (i_sys_aresetn),
      .load      (accept),
      .load_data (next_tdata),
      .load_user (next_user),
      .load_last (next_last),
      .tready    (m_axis_tready),
      .tdata     (m_axis_tdata),
      .tvalid    (m_axis_tvalid),
      .tuser     (m_axis_tuser),
      .tlast     (m_axis_tlast)
   );

   // BLANK counts cycles whose next output is idle, so a stalled tlast beat never shortens the gap
   // and the next line's pixel accept lands on the last idle cycle.
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) begin
         state        <= IDLE;
         width_l      <= '0;
         height_l     <= '0;
         thr_l        <= '0;
         pix_cnt      <= '0;
         line_cnt     <= '0;
         blank_cnt    <= '0;
         o_busy       <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         o_frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start && (WIDTH >= 11'd4) && (HEIGHT >= 11'd1)) begin
                  width_l  <= WIDTH;
                  height_l <= HEIGHT;
                  thr_l    <= i_threshold;
                  pix_cnt  <= '0;
                  line_cnt <= '0;
                  o_busy   <= 1'b1;
                  state    <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (accept) begin
                  if (pix_cnt == width_l - 11'd1) begin
                     pix_cnt   <= '0;
                     line_cnt  <= line_cnt + 11'd1;
                     blank_cnt <= '0;
                     state     <= (line_cnt == height_l - 11'd1) ? FRAME_END : BLANK;
                  end else begin
                     pix_cnt <= pix_cnt + 11'd1;
                  end
               end
            end
            BLANK: begin
               if (!m_axis_tvalid || m_axis_tready) begin
                  if (blank_cnt == BLANK_LAST) begin
                     state <= ACTIVE;
                  end else begin
                     blank_cnt <= blank_cnt + 4'd1;
                  end
               end
            end
            FRAME_END: begin
               if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                  o_frame_done <= 1'b1;
                  o_busy       <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cog_axis_frame_tx.sv
// Directed self-checking bench for cog_axis_frame_tx: 8x2 frames, backpressure, ignored starts, reset.
module tb_cog_axis_frame_tx;

   logic        i_sys_clk = 1'b0;
   logic        i_sys_aresetn;
   logic [10:0] WIDTH;
   logic [10:0] HEIGHT;
   logic        i_start;
   logic [7:0]  i_threshold;
   logic [7:0]  i_pix_data;
   logic        i_pix_valid;
   logic        o_pix_ready;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tuser;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        o_busy;
   logic        o_frame_done;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  pixels [16];
   logic [15:0] beat_data [16];
   logic        beat_user [16];
   logic        beat_last [16];
   int          gap_before [17];
   int          beats;
   int          done_pulses;
   bit          finished;

   always #5 i_sys_clk = ~i_sys_clk;

   cog_axis_frame_tx dut (
      .i_sys_clk     (i_sys_clk),
      .i_sys_aresetn (i_sys_aresetn),
      .WIDTH         (WIDTH),
      .HEIGHT        (HEIGHT),
      .i_start       (i_start),
      .i_threshold   (i_threshold),
      .i_pix_data    (i_pix_data),
      .i_pix_valid   (i_pix_valid),
      .o_pix_ready   (o_pix_ready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .o_busy        (o_busy),
      .o_frame_done  (o_frame_done)
   );

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Expected beat for an 8-wide frame with threshold 0x80.
   function automatic logic [15:0] exp_tdata(input int idx);
      logic [7:0] p;
      p = pixels[idx];
`ifdef CoG_TX_BORDER_BLACK_EN
      if ((idx % 8) < 2 || (idx % 8) >= 6) return 16'h0000;
`endif
      return {(p >= 8'h80) ? 8'hFF : 8'h00, p};
   endfunction

   // Runs one 8x2 frame; optionally stalls one beat, pulses a mid-frame start, or aborts after some beats.
   task automatic apply_stimulus(input int stall_beat, input int stall_len, input int restart_cyc,
                                 input int abort_beat);
      int  pix_idx;
      int  stall_cnt;
      int  low_run;
      bit  acc_prev;
      bit  cur_seen;
      beats       = 0;
      done_pulses = 0;
      finished    = 1'b0;
      pix_idx     = 0;
      stall_cnt   = 0;
      low_run     = 0;
      acc_prev    = 1'b0;
      cur_seen    = 1'b0;
      for (int i = 0; i < 17; i++) gap_before[i] = -1;
      @(negedge i_sys_clk);
      i_start       = 1'b1;
      WIDTH         = 11'd8;
      HEIGHT        = 11'd2;
      i_threshold   = 8'h80;
      i_pix_valid   = 1'b1;
      i_pix_data    = pixels[0];
      m_axis_tready = 1'b1;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         @(negedge i_sys_clk);
         i_start = 1'b0;
         if (acc_prev) begin
            pix_idx++;
            i_pix_valid = (pix_idx < 16);
            i_pix_data  = (pix_idx < 16) ? pixels[pix_idx] : 8'h00;
         end
         if (cyc == restart_cyc) begin
            i_start     = 1'b1;
            WIDTH       = 11'd5;
            HEIGHT      = 11'd1;
            i_threshold = 8'h00;
         end
         m_axis_tready = !(m_axis_tvalid && beats == stall_beat && stall_cnt < stall_len);
         #1;
         if (cyc == restart_cyc) check_output("restart_busy", 32'(o_busy), 32'd1);
         if (!m_axis_tready) begin
            stall_cnt++;
            check_output("stall_tdata", 32'(m_axis_tdata), 32'(exp_tdata(stall_beat)));
            check_output("stall_tuser", 32'(m_axis_tuser), 32'(stall_beat == 0));
            check_output("stall_tlast", 32'(m_axis_tlast), 32'((stall_beat % 8) == 7));
            check_output("stall_ready", 32'(o_pix_ready), 32'd0);
         end
         if (!m_axis_tvalid) begin
            low_run++;
         end else if (!cur_seen) begin
            if (beats < 17) gap_before[beats] = low_run;
            cur_seen = 1'b1;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (beats < 16) begin
               beat_data[beats] = m_axis_tdata;
               beat_user[beats] = m_axis_tuser;
               beat_last[beats] = m_axis_tlast;
            end
            beats++;
            cur_seen = 1'b0;
            low_run  = 0;
         end
         acc_prev = i_pix_valid && o_pix_ready;
         if (o_frame_done) begin
            done_pulses++;
            check_output("done_busy", 32'(o_busy), 32'd0);
            finished = 1'b1;
         end
         if (beats == abort_beat) finished = 1'b1;
      end
      check_output("frame_timeout", 32'(finished), 32'd1);
      if (abort_beat > 16) begin
         repeat (3) begin
            @(negedge i_sys_clk);
            #1;
            if (o_frame_done) done_pulses++;
         end
      end
   endtask

   task automatic verify_frame(input string name);
      check_output({name, "_beats"}, 32'(beats), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check_output($sformatf("%s_beat%0d_tdata", name, i), 32'(beat_data[i]), 32'(exp_tdata(i)));
         check_output($sformatf("%s_beat%0d_tuser", name, i), 32'(beat_user[i]), 32'(i == 0));
         check_output($sformatf("%s_beat%0d_tlast", name, i), 32'(beat_last[i]), 32'((i % 8) == 7));
      end
      check_output({name, "_hblank_gap"}, 32'(gap_before[8]), 32'd4);
      check_output({name, "_done_pulses"}, 32'(done_pulses), 32'd1);
      check_output({name, "_busy_after"}, 32'(o_busy), 32'd0);
   endtask

   task automatic check_all_zero(input string name);
      check_output({name, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
      check_output({name, "_tuser"}, 32'(m_axis_tuser), 32'd0);
      check_output({name, "_tlast"}, 32'(m_axis_tlast), 32'd0);
      check_output({name, "_tdata"}, 32'(m_axis_tdata), 32'd0);
      check_output({name, "_busy"}, 32'(o_busy), 32'd0);
      check_output({name, "_done"}, 32'(o_frame_done), 32'd0);
      check_output({name, "_ready"}, 32'(o_pix_ready), 32'd0);
   endtask

   initial begin
      i_sys_aresetn = 1'b0;
      WIDTH         = 11'd0;
      HEIGHT        = 11'd0;
      i_start       = 1'b0;
      i_threshold   = 8'h00;
      i_pix_data    = 8'h00;
      i_pix_valid   = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 16; i++) pixels[i] = 8'(i);

      repeat (2) @(negedge i_sys_clk);
      #1;
      check_all_zero("reset");
      i_sys_aresetn = 1'b1;

      $display("[TB] frame with pixels 0x00..0x0F");
      apply_stimulus(99, 0, -1, 99);
      verify_frame("plain");

      $display("[TB] frame with pixels above and equal to threshold");
      pixels[5] = 8'h90;
      pixels[6] = 8'h80;
      apply_stimulus(99, 0, -1, 99);
      verify_frame("thresh");

      $display("[TB] beat 2 stalled 5 cycles plus a mid-frame start");
      apply_stimulus(2, 5, 6, 99);
      verify_frame("stall");

      $display("[TB] tlast beat stalled 3 cycles");
      apply_stimulus(7, 3, -1, 99);
      verify_frame("last_stall");

      $display("[TB] start with WIDTH 3 is ignored");
      @(negedge i_sys_clk);
      i_start     = 1'b1;
      WIDTH       = 11'd3;
      HEIGHT      = 11'd2;
      i_pix_valid = 1'b1;
      @(negedge i_sys_clk);
      i_start = 1'b0;
      repeat (4) begin
         @(negedge i_sys_clk);
         #1;
         check_output("narrow_busy", 32'(o_busy), 32'd0);
         check_output("narrow_tvalid", 32'(m_axis_tvalid), 32'd0);
      end

      $display("[TB] reset in the middle of line 1");
      apply_stimulus(99, 0, -1, 10);
      i_sys_aresetn = 1'b0;
      #1;
      check_all_zero("midreset");
      @(negedge i_sys_clk);
      i_sys_aresetn = 1'b1;
      apply_stimulus(99, 0, -1, 99);
      verify_frame("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
